// File: rtl/uart_tx_pixel.sv
// UART transmitter for 24-bit RGB pixels: red, green, blue as three 8N1 bytes, LSB first.
// Define UART_TX_STOP2_EN to send two stop bits per byte instead of one.
module uart_tx_pixel #(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE     = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] pixel,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_STOP2_EN
  localparam logic [2:0] STOP_LAST = 3'd1;
`else
  localparam logic [2:0] STOP_LAST = 3'd0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Handshake: a pixel moves on any rising edge where pixel_valid && pixel_ready;
  // pixel_ready is high exactly while IDLE, and inputs are ignored otherwise.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      pixel_q, pixel_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;

  logic [7:0] cur_byte;
  logic [2:0] next_bit;
  logic       baud_last;

  always_comb begin
    case (byte_idx_q)
      2'd0:    cur_byte = pixel_q[23:16];
      2'd1:    cur_byte = pixel_q[15:8];
      default: cur_byte = pixel_q[7:0];
    endcase
  end

  assign next_bit  = bit_idx_q + 3'd1;
  assign baud_last = (baud_cnt_q == BAUD_MAX);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    pixel_d    = pixel_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
        if (pixel_valid) begin
          pixel_d    = pixel;
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd0;
          state_d    = START;
          tx_d       = 1'b0;
        end
      end

      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = DATA;
          tx_d       = cur_byte[0];
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = STOP;
            tx_d      = 1'b1;
          end else begin
            bit_idx_d = next_bit;
            tx_d      = cur_byte[next_bit];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_cnt_d = '0;
          // bit_idx doubles as the stop-bit counter while in STOP
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = 3'd0;
            if (byte_idx_q == 2'd2) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
              state_d    = START;
              tx_d       = 1'b0;
            end
          end else begin
            bit_idx_d = next_bit;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      pixel_q    <= 24'd0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      pixel_q    <= pixel_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx          = tx_q;
  assign done        = done_q;
  assign pixel_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_pixel.sv
// Bench for uart_tx_pixel at N = 10 clocks per bit; frame bytes are predicted into a
// queue on acceptance and popped as each byte is decoded from the line.
module tb_uart_tx_pixel;

  localparam int N = 10;
`ifdef UART_TX_STOP2_EN
  localparam int STOP_N = 2;
`else
  localparam int STOP_N = 1;
`endif
  localparam int BYTE_CYC = (9 + STOP_N) * N;
  localparam int FRAME    = 3 * BYTE_CYC;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        tx;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];

  logic tx_s   [0:FRAME+1];
  logic done_s [0:FRAME+1];
  logic rdy_s  [0:FRAME+1];
  logic busy_s [0:FRAME+1];

  uart_tx_pixel #(
    .CLK_FREQUENCY(1000000),
    .BAUD_RATE    (100000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pixel      (pixel),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1ns after the accepting edge, i.e. inside cycle 1 of the frame.
  task automatic send(input logic [23:0] px, input bit hold);
    int waited;
    pixel       = px;
    pixel_valid = 1'b1;
    waited      = 0;
    while (pixel_ready !== 1'b1 && waited < 1000) begin
      step();
      waited++;
    end
    checks++;
    if (waited >= 1000) begin
      errors++;
      $display("FAIL send_timeout: pixel_ready=%b required 1 within 1000 cycles", pixel_ready);
    end
    step();
    exp_q.push_back(px[23:16]);
    exp_q.push_back(px[15:8]);
    exp_q.push_back(px[7:0]);
    if (!hold) pixel_valid = 1'b0;
  endtask

  // Records cycles 1..FRAME+1 after acceptance and checks framing, bytes and done timing.
  task automatic watch_frame(input string name, input bit wiggle);
    int base;
    int bad;
    logic [7:0] got;
    logic [7:0] exp;
    for (int k = 1; k <= FRAME + 1; k++) begin
      tx_s[k]   = tx;
      done_s[k] = done;
      rdy_s[k]  = pixel_ready;
      busy_s[k] = busy;
      if (wiggle) begin
        pixel       = 24'hFFFFFF;
        pixel_valid = (k <= FRAME) ? k[0] : 1'b0;
      end
      if (k <= FRAME) step();
    end

    for (int b = 0; b < 3; b++) begin
      base = b * BYTE_CYC;
      bad  = 0;
      for (int c = 1; c <= N; c++) if (tx_s[base + c] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s_start%0d: %0d cycles not low, required 0", name, b, bad);
      end
      for (int i = 0; i < 8; i++) got[i] = tx_s[base + (i + 1) * N + N / 2];
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_byte%0d: got %h, expected queue empty", name, b, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL %s_byte%0d: got %h required %h", name, b, got, exp);
        end
      end
      bad = 0;
      for (int c = 9 * N + 1; c <= BYTE_CYC; c++) if (tx_s[base + c] !== 1'b1) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s_stop%0d: %0d cycles not high, required 0", name, b, bad);
      end
    end

    bad = 0;
    for (int k = 1; k <= FRAME; k++)
      if (rdy_s[k] !== 1'b0 || busy_s[k] !== 1'b1 || done_s[k] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_busy_window: %0d cycles with wrong ready/busy/done, required 0", name, bad);
    end

    checks++;
    if ({tx_s[FRAME+1], done_s[FRAME+1], rdy_s[FRAME+1], busy_s[FRAME+1]} !== 4'b1110) begin
      errors++;
      $display("FAIL %s_end_cycle: tx,done,ready,busy=%b%b%b%b required 1110", name,
               tx_s[FRAME+1], done_s[FRAME+1], rdy_s[FRAME+1], busy_s[FRAME+1]);
    end
  endtask

  task automatic test_reset();
    int bad;
    reset       = 1'b1;
    pixel_valid = 1'b1;
    pixel       = 24'h000000;
    repeat (3) step();
    checks++;
    if ({tx, pixel_ready, busy, done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_held: tx,ready,busy,done=%b%b%b%b required 1100", tx, pixel_ready, busy, done);
    end
    pixel_valid = 1'b0;
    reset       = 1'b0;
    step();
    checks++;
    if ({tx, pixel_ready, busy, done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release: tx,ready,busy,done=%b%b%b%b required 1100", tx, pixel_ready, busy, done);
    end
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle_line: %0d cycles not idle, required 0", bad);
    end
  endtask

  task automatic test_single();
    send(24'hA53C0F, 1'b0);
    watch_frame("single", 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    send(24'h000000, 1'b1);
    pixel = 24'hFFFFFF;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    watch_frame("b2b_first", 1'b0);
    step();
    pixel_valid = 1'b0;
    watch_frame("b2b_second", 1'b0);
    step();
  endtask

  task automatic test_busy_hold();
    int bad;
    send(24'h123456, 1'b0);
    watch_frame("hold", 1'b1);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_no_extra_frame: %0d non-idle cycles, required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    send(24'h000000, 1'b0);
    repeat (149) step();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: tx,busy=%b%b required 01", tx, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({tx, busy, pixel_ready} !== 3'b101) begin
      errors++;
      $display("FAIL midreset_async: tx,busy,ready=%b%b%b required 101", tx, busy, pixel_ready);
    end
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done !== 1'b0 || tx !== 1'b1) bad++;
    end
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_aborted: %0d cycles with done or activity, required 0", bad);
    end
    exp_q.delete();
    send(24'h0F0F0F, 1'b0);
    watch_frame("after_reset", 1'b0);
    step();
  endtask

`ifdef UART_TX_STOP2_EN
  task automatic test_stop2();
    send(24'h010203, 1'b0);
    watch_frame("stop2", 1'b0);
    step();
  endtask
`endif

  initial begin
    reset       = 1'b1;
    pixel_valid = 1'b0;
    pixel       = 24'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_hold();
    test_reset_mid();
`ifdef UART_TX_STOP2_EN
    test_stop2();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: %0d bytes never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
